// File: rtl/apb_global_pkg.sv
// Shared APB slave definitions: bus geometry defaults, FSM state encoding and
// transfer direction encoding used by the responder and its bench.
package apb_global_pkg;

    localparam int ADDRESS_WIDTH  = 32;
    localparam int DATA_WIDTH     = 32;
    localparam int MIN_ADDR_RANGE = 0;
    localparam int MAX_ADDR_RANGE = 32;
    localparam int WAIT_WIDTH     = 4;

    typedef enum logic [1:0] {
        IDLE_STATE   = 2'd0,
        SETUP_STATE  = 2'd1,
        ACCESS_STATE = 2'd2
    } operation_states_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } tx_type_e;

endpackage : apb_global_pkg

// File: rtl/apb_slave_regfile.sv
// Word-addressed storage for the APB responder: byte-strobed synchronous write
// port, one combinational read port, whole array cleared by synchronous reset.
module apb_slave_regfile #(
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH       = 8,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_we,
    input  logic [INDEX_WIDTH-1:0]  i_waddr,
    input  logic [WORD_WIDTH/8-1:0] i_wstrb,
    input  logic [WORD_WIDTH-1:0]   i_wdata,
    input  logic [INDEX_WIDTH-1:0]  i_raddr,
    output logic [WORD_WIDTH-1:0]   o_rdata
);

    localparam int BYTES = WORD_WIDTH / 8;

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        // NOTE: the array is reset word by word because software relies on
        // reading zeros after reset; that forces flops rather than a RAM macro.
        if (i_rst) begin
            for (int w = 0; w < DEPTH; w++) begin
                r_mem[w] <= '0;
            end
        end else if (i_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : apb_slave_regfile

// File: rtl/apb_slave_responder.sv
// APB completer with programmable wait states, address-range/alignment error
// response and byte-strobed word storage. Bus outputs come from registers only.
module apb_slave_responder
    import apb_global_pkg::operation_states_e;
    import apb_global_pkg::IDLE_STATE;
    import apb_global_pkg::ACCESS_STATE;
    import apb_global_pkg::tx_type_e;
    import apb_global_pkg::READ;
    import apb_global_pkg::WRITE;
    import apb_global_pkg::WAIT_WIDTH;
#(
    parameter int ADDRESS_WIDTH  = apb_global_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = apb_global_pkg::DATA_WIDTH,
    parameter int MIN_ADDR_RANGE = apb_global_pkg::MIN_ADDR_RANGE,
    parameter int MAX_ADDR_RANGE = apb_global_pkg::MAX_ADDR_RANGE
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    input  logic [WAIT_WIDTH-1:0]     cfg_wait_cycles,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pready,
    output logic                      pslverr
);

    localparam int BYTES       = DATA_WIDTH / 8;
    localparam int STRB_LSB    = $clog2(BYTES);
    localparam int DEPTH       = (MAX_ADDR_RANGE - MIN_ADDR_RANGE) / BYTES;
    localparam int INDEX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    operation_states_e r_state;
    operation_states_e w_state_next;
    logic [WAIT_WIDTH-1:0] r_count;
    logic [WAIT_WIDTH-1:0] w_count_next;
    logic                  w_capture;

    logic [ADDRESS_WIDTH-1:0] r_addr;
    tx_type_e                 r_tx;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [BYTES-1:0]         r_strb;
    logic [2:0]               r_prot;
    logic                     r_err;

    logic [ADDRESS_WIDTH-1:0] w_min;
    logic [ADDRESS_WIDTH-1:0] w_max;
    logic                     w_addr_err;
    logic                     w_done;
    logic                     w_we;
    logic [INDEX_WIDTH-1:0]   w_index;
    logic [DATA_WIDTH-1:0]    w_rdata;
    logic                     w_unused_prot;

    // Range bounds held in nets so the checks stay generic for any MIN/MAX.
    assign w_min = ADDRESS_WIDTH'(MIN_ADDR_RANGE);
    assign w_max = ADDRESS_WIDTH'(MAX_ADDR_RANGE);

    assign w_addr_err = (paddr < w_min) || (paddr >= w_max) ||
                        (paddr[STRB_LSB-1:0] != '0);

    // Protection attributes are captured for visibility but do not gate access.
    assign w_unused_prot = ^r_prot;

    always_ff @(posedge pclk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (preset) begin
            r_state <= IDLE_STATE;
            r_count <= '0;
            r_addr  <= '0;
            r_tx    <= READ;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_capture) begin
                r_addr  <= paddr;
                r_tx    <= tx_type_e'(pwrite);
                r_wdata <= pwdata;
                r_strb  <= pstrb;
                r_prot  <= pprot;
                r_err   <= w_addr_err;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_count_next = r_count;
        w_capture    = 1'b0;

        case (r_state)
            ACCESS_STATE: begin
                if (r_count == '0) begin
                    w_state_next = IDLE_STATE;
                end else if (psel && penable) begin
                    w_count_next = r_count - WAIT_WIDTH'(1);
                end else begin
                    w_state_next = IDLE_STATE;
                    w_count_next = '0;
                end
            end
            // IDLE and the unused SETUP encoding share the setup-phase decode.
            default: begin
                if (psel && !penable) begin
                    w_capture    = 1'b1;
                    w_count_next = cfg_wait_cycles;
                    w_state_next = ACCESS_STATE;
                end
            end
        endcase
    end

    assign w_done  = (r_state == ACCESS_STATE) && (r_count == '0);
    assign w_we    = w_done && (r_tx == WRITE) && !r_err;
    assign w_index = r_err ? '0
                           : INDEX_WIDTH'((r_addr - w_min) >> STRB_LSB);

    apb_slave_regfile #(
        .WORD_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_regfile (
        .i_clk   (pclk),
        .i_rst   (preset),
        .i_we    (w_we),
        .i_waddr (w_index),
        .i_wstrb (r_strb),
        .i_wdata (r_wdata),
        .i_raddr (w_index),
        .o_rdata (w_rdata)
    );

    assign pready  = w_done;
    assign pslverr = w_done && r_err;
    assign prdata  = (w_done && (r_tx == READ) && !r_err) ? w_rdata : '0;

endmodule : apb_slave_responder

// File: tb/tb_apb_slave_responder.sv
// Directed bench for apb_slave_responder: latency, byte strobes, error
// responses, abort, back-to-back transfers and mid-transfer reset.
module tb_apb_slave_responder;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic [3:0]  cfg_wait_cycles = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    apb_slave_responder dut (
        .pclk            (pclk),
        .preset          (preset),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .paddr           (paddr),
        .pwdata          (pwdata),
        .pstrb           (pstrb),
        .pprot           (pprot),
        .cfg_wait_cycles (cfg_wait_cycles),
        .prdata          (prdata),
        .pready          (pready),
        .pslverr         (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Full transfer: setup, then access cycles until pready (bounded at 40).
    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic [3:0] wt, input logic exp_err,
                        input logic [31:0] exp_rdata);
        int  lows;
        logic done;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wdata; pstrb = strb; pprot = 3'b010; cfg_wait_cycles = wt;
        lows = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge pclk); #1;
            penable = 1'b1;
            cfg_wait_cycles = wt ^ 4'hA;
            if (pready) begin
                done = 1'b1;
            end else begin
                lows++;
                check({tag, "_wait_prdata"}, prdata, 32'h0);
            end
        end
        check({tag, "_lat"}, 32'(lows), 32'(wt));
        check({tag, "_err"}, {31'h0, pslverr}, {31'h0, exp_err});
        if (!wr) begin
            check({tag, "_rdata"}, prdata, exp_rdata);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            psel = 1'b0; penable = 1'b0;
            check({tag, "_idle_rdy"}, {31'h0, pready}, 32'h0);
        end
    endtask

    initial begin
        repeat (2) @(posedge pclk);
        #1;
        check("rst_pready", {31'h0, pready}, 32'h0);
        check("rst_pslverr", {31'h0, pslverr}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        preset = 1'b0;

        xfer("wr04", 32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 4'd0, 1'b0, 32'h0);
        xfer("rd04", 32'h04, 1'b0, 32'h0, 4'h0, 4'd0, 1'b0, 32'hDEADBEEF);
        idle("a", 1);
        xfer("rd08", 32'h08, 1'b0, 32'h0, 4'h0, 4'd3, 1'b0, 32'h0);
        idle("b", 1);

        // Back-to-back: each setup lands in the cycle right after pready.
        xfer("wr0c_full", 32'h0C, 1'b1, 32'h11223344, 4'hF, 4'd1, 1'b0, 32'h0);
        xfer("wr0c_strb", 32'h0C, 1'b1, 32'hAABBCCDD, 4'h5, 4'd2, 1'b0, 32'h0);
        xfer("rd0c", 32'h0C, 1'b0, 32'h0, 4'h0, 4'd0, 1'b0, 32'h11BB33DD);
        idle("c", 1);

        xfer("wr20", 32'h20, 1'b1, 32'h12345678, 4'hF, 4'd1, 1'b1, 32'h0);
        xfer("wr02", 32'h02, 1'b1, 32'h87654321, 4'hF, 4'd0, 1'b1, 32'h0);
        xfer("rd20", 32'h20, 1'b0, 32'h0, 4'h0, 4'd0, 1'b1, 32'h0);
        xfer("rd00_after_err", 32'h00, 1'b0, 32'h0, 4'h0, 4'd0, 1'b0, 32'h0);
        xfer("rd04_after_err", 32'h04, 1'b0, 32'h0, 4'h0, 4'd0, 1'b0, 32'hDEADBEEF);
        xfer("rd0c_after_err", 32'h0C, 1'b0, 32'h0, 4'h0, 4'd0, 1'b0, 32'h11BB33DD);

        xfer("wr04_nostrb", 32'h04, 1'b1, 32'hFFFFFFFF, 4'h0, 4'd0, 1'b0, 32'h0);
        xfer("rd04_nostrb", 32'h04, 1'b0, 32'h0, 4'h0, 4'd0, 1'b0, 32'hDEADBEEF);
        xfer("wr1c", 32'h1C, 1'b1, 32'hA5A5_0F0F, 4'hF, 4'd15, 1'b0, 32'h0);
        xfer("rd1c", 32'h1C, 1'b0, 32'h0, 4'h0, 4'd15, 1'b0, 32'hA5A5_0F0F);

        // Access phase with no preceding setup must not start a transfer.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h08;
        pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            check("stray_access_rdy", {31'h0, pready}, 32'h0);
        end
        idle("d", 1);
        xfer("rd08_after_stray", 32'h08, 1'b0, 32'h0, 4'h0, 4'd0, 1'b0, 32'h0);

        // Abort: deselect after two wait cycles of a 5-wait write.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 32'h55AA55AA; pstrb = 4'hF; cfg_wait_cycles = 4'd5;
        for (int i = 0; i < 2; i++) begin
            @(posedge pclk); #1;
            penable = 1'b1;
            check("abort_wait_rdy", {31'h0, pready}, 32'h0);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        check("abort_drop_rdy", {31'h0, pready}, 32'h0);
        idle("abort", 6);
        xfer("rd10_after_abort", 32'h10, 1'b0, 32'h0, 4'h0, 4'd0, 1'b0, 32'h0);

        // Reset during the wait states of a write to word 0.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF; cfg_wait_cycles = 4'd4;
        for (int i = 0; i < 2; i++) begin
            @(posedge pclk); #1;
            penable = 1'b1;
        end
        @(posedge pclk); #1;
        preset = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        check("midrst_pready", {31'h0, pready}, 32'h0);
        check("midrst_pslverr", {31'h0, pslverr}, 32'h0);
        check("midrst_prdata", prdata, 32'h0);
        preset = 1'b0;
        idle("post_rst", 3);
        xfer("rd00_after_rst", 32'h00, 1'b0, 32'h0, 4'h0, 4'd0, 1'b0, 32'h0);
        xfer("rd04_after_rst", 32'h04, 1'b0, 32'h0, 4'h0, 4'd1, 1'b0, 32'h0);
        xfer("rd1c_after_rst", 32'h1C, 1'b0, 32'h0, 4'h0, 4'd0, 1'b0, 32'h0);
        idle("end", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_slave_responder
